// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: word width, NOP encoding,
// controller states and the per-word parity helper.
package imem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        BOOT_LOAD = 1'b0,
        RUN       = 1'b1
    } imem_state_t;

    // Even parity: the stored bit makes the XOR over {bit, word} equal zero.
    function automatic logic even_parity(input logic [WORD_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/imem_array.sv
// 1R1W synchronous RAM with a registered read port; the read register only updates
// on a read enable, so its output stays stable while the consumer stalls.
import imem_pkg::*;

module imem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = WORD_W,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Storage write and registered read; contents are intentionally never cleared.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loadable.sv
// Boot-loadable MIPS instruction memory with a one-entry valid/ready fetch output.
// Define IMEM_PARITY_EN to store and check one even-parity bit per word.
import imem_pkg::*;

module instr_mem_loadable #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              boot_done,
    output logic [IDX_W:0]    load_count,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              instr_valid,
    output logic [31:0]       instr,
    input  logic              instr_ready,
    output logic              fetch_err
);

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = WORD_W + 1;
`else
    localparam int MEM_W = WORD_W;
`endif

    imem_state_t      r_state;
    imem_state_t      w_state_nxt;
    logic [IDX_W:0]   r_count;
    logic             r_instr_valid;
    logic             r_nop;
    logic             r_addr_err;
    logic             r_chk;
    logic             w_load_we;
    logic             w_grant;
    logic [IDX_W-1:0] w_idx;
    logic             w_misal;
    logic             w_oor;
    logic             w_unloaded;
    logic             w_par_err;
    logic [MEM_W-1:0] w_wdata;
    logic [MEM_W-1:0] w_rdata;

    assign w_load_we  = (r_state == BOOT_LOAD) && load_valid;
    assign w_grant    = (r_state == RUN) && fetch_req && (!r_instr_valid || instr_ready);
    assign w_idx      = fetch_addr[IDX_W+1:2];
    assign w_misal    = |fetch_addr[1:0];
    assign w_oor      = |fetch_addr[ADDR_W-1:IDX_W+2];
    assign w_unloaded = ({1'b0, w_idx} >= r_count);

`ifdef IMEM_PARITY_EN
    assign w_wdata   = {even_parity(load_data), load_data};
    assign w_par_err = r_chk && (^w_rdata);
`else
    assign w_wdata   = load_data;
    assign w_par_err = 1'b0;
`endif

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (MEM_W)
    ) u_array (
        .clk     (clk),
        .i_we    (w_load_we),
        .i_waddr (r_count[IDX_W-1:0]),
        .i_wdata (w_wdata),
        .i_re    (w_grant),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Boot load ends after the last-flagged word or once the final index is written.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            BOOT_LOAD: begin
                if (w_load_we && (load_last || (r_count[IDX_W-1:0] == IDX_W'(DEPTH - 1)))) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = BOOT_LOAD;
                end
            end
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = BOOT_LOAD;
        endcase
    end

    // Load pointer doubles as the loaded-word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_load_we) begin
            r_count <= r_count + (IDX_W+1)'(1);
        end
    end

    // Output handshake register; the NOP/error decision travels with the read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_valid <= 1'b0;
            r_nop         <= 1'b1;
            r_addr_err    <= 1'b0;
            r_chk         <= 1'b0;
        end else if (w_grant) begin
            r_instr_valid <= 1'b1;
            r_nop         <= w_misal || w_oor || w_unloaded;
            r_addr_err    <= w_misal || w_oor;
            r_chk         <= !(w_misal || w_oor || w_unloaded);
        end else if (instr_ready) begin
            r_instr_valid <= 1'b0;
        end
    end

    assign load_ready  = (r_state == BOOT_LOAD);
    assign boot_done   = (r_state == RUN);
    assign load_count  = r_count;
    assign fetch_gnt   = w_grant;
    assign instr_valid = r_instr_valid;
    assign instr       = (r_nop || w_par_err) ? NOP_WORD : w_rdata[WORD_W-1:0];
    assign fetch_err   = r_addr_err || w_par_err;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: directed scenarios plus randomized
// load/fetch traffic compared against an array-based behavioural model.
module tb_instr_mem_loadable;

    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int IDX_W  = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst, load_valid, load_last, fetch_req, instr_ready;
    logic [31:0]       load_data;
    logic [ADDR_W-1:0] fetch_addr;
    logic              load_ready, boot_done, fetch_gnt, instr_valid, fetch_err;
    logic [IDX_W:0]    load_count;
    logic [31:0]       instr;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state
    logic [31:0] m_mem [DEPTH];
    bit          m_bad [DEPTH];
    int          m_count;
    bit          m_run, m_valid, m_err;
    logic [31:0] m_instr;

    logic [31:0] prog [5] = '{32'h20010003, 32'h20020009, 32'h00221020, 32'h00221824, 32'h00222025};

    always #5 clk = ~clk;

    instr_mem_loadable #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready), .boot_done(boot_done),
        .load_count(load_count), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .fetch_err(fetch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_count = 0; m_valid = 1'b0; m_instr = 32'h0; m_err = 1'b0;
    endtask

    // One clock: check grant before the edge, advance the model, check state after it.
    task automatic tick();
        bit gnt;
        #1;
        gnt = m_run && fetch_req && (!m_valid || instr_ready);
        check("fetch_gnt", {31'b0, fetch_gnt}, {31'b0, gnt});
        check("load_ready", {31'b0, load_ready}, {31'b0, !m_run});
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_run) begin
            if (load_valid) begin
                m_mem[m_count] = load_data;
                m_bad[m_count] = 1'b0;
                m_count++;
                if (load_last || m_count == DEPTH) m_run = 1'b1;
            end
        end else if (gnt) begin
            m_valid = 1'b1;
            if (fetch_addr % 4 != 0 || fetch_addr / 4 >= DEPTH) begin
                m_instr = 32'h0; m_err = 1'b1;
            end else if (fetch_addr / 4 >= m_count) begin
                m_instr = 32'h0; m_err = 1'b0;
            end else if (m_bad[fetch_addr / 4]) begin
                m_instr = 32'h0; m_err = 1'b1;
            end else begin
                m_instr = m_mem[fetch_addr / 4]; m_err = 1'b0;
            end
        end else if (instr_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check("load_count", 32'(load_count), 32'(m_count));
        check("boot_done", {31'b0, boot_done}, {31'b0, m_run});
        check("instr_valid", {31'b0, instr_valid}, {31'b0, m_valid});
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
        end
    endtask

    task automatic idle();
        load_valid = 1'b0; load_last = 1'b0; fetch_req = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] d, input bit last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        idle();
    endtask

    task automatic fetch(input logic [31:0] a, input bit rdy);
        fetch_req = 1'b1; fetch_addr = a; instr_ready = rdy;
        tick();
    endtask

    task automatic do_reset();
        idle(); rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_instr", instr, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'h0);
        check("rst_count", 32'(load_count), 32'h0);
    endtask

    task automatic random_fetch(input int n);
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 4);
            fetch_req   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 3) != 0);
            case (kind)
                0: fetch_addr = 32'($urandom_range(0, DEPTH - 1)) << 2;
                1: fetch_addr = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
                2: fetch_addr = ($urandom() & 32'hFFFF_FFFC) | 32'(DEPTH * 4);
                default: fetch_addr = 32'($urandom_range(0, (m_count > 0) ? m_count - 1 : 0)) << 2;
            endcase
            load_valid = $urandom_range(0, 1);
            load_data  = $urandom();
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;
        rst = 1'b1; idle(); instr_ready = 1'b1; load_data = 32'h0; fetch_addr = '0;
        repeat (2) @(posedge clk);
        model_reset();
        do_reset();

        // Fetch attempts during boot load are not granted.
        fetch(32'h0, 1'b1);
        idle();
        for (int i = 0; i < 5; i++) load_word(prog[i], i == 4);
        check("t1_count", 32'(load_count), 32'd5);

        for (int i = 0; i < 5; i++) fetch(32'(i * 4), 1'b1);
        fetch(32'h14, 1'b1);
        fetch(32'h6, 1'b1);
        fetch(32'(DEPTH * 4), 1'b1);

        // Stall: output held for three cycles, then a grant with ready high.
        fetch(32'h4, 1'b1);
        for (int i = 0; i < 3; i++) fetch(32'h8, 1'b0);
        check("t3_hold", instr, 32'h20020009);
        fetch(32'h8, 1'b1);
        check("t3_next", instr, 32'h00221020);
        idle(); instr_ready = 1'b1;
        tick();

        // Loads ignored in RUN.
        load_word(32'hDEAD_BEEF, 1'b1);
        load_word(32'h1234_5678, 1'b0);

`ifdef IMEM_PARITY_EN
        #2;
        u_dut.u_array.r_mem[1][32] = ~u_dut.u_array.r_mem[1][32];
        m_bad[1] = 1'b1;
        fetch(32'h4, 1'b1);
        check("t6_par_instr", instr, 32'h0);
        check("t6_par_err", {31'b0, fetch_err}, 32'h1);
        fetch(32'h0, 1'b1);
        check("t6_idx0", instr, 32'h20010003);
        idle(); tick();
`endif

        // Reset mid-fetch, then mid-load, then a short reload over stale contents.
        fetch(32'h0, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) load_word(prog[i], 1'b0);
        do_reset();
        load_word(32'h2003_0001, 1'b0);
        load_word(32'h2004_0002, 1'b1);
        fetch(32'h8, 1'b1);
        check("t5_nop", instr, 32'h0);
        check("t5_err", {31'b0, fetch_err}, 32'h0);
        random_fetch(200);

        // Random-length load with gaps, then random traffic.
        do_reset();
        begin
            int n = $urandom_range(10, 60);
            int k = 0;
            while (k < n) begin
                load_valid = $urandom_range(0, 1);
                load_data  = $urandom();
                load_last  = (k == n - 1);
                if (load_valid) k++;
                tick();
            end
            idle();
        end
        random_fetch(300);

        // Full-depth load ends boot without load_last.
        do_reset();
        for (int i = 0; i < DEPTH; i++) load_word($urandom(), 1'b0);
        check("full_boot", {31'b0, boot_done}, 32'h1);
        fetch(32'((DEPTH - 1) * 4), 1'b1);
        check("full_last", instr, m_mem[DEPTH - 1]);
        random_fetch(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
